// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - EX-to-divider request/response bundle; DIV_ZERO_FLAG_EN adds div_zero_o
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic                 div_zero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, div_zero_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, div_zero_o
  );
`else
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
`endif
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - one-bit-per-cycle restoring divider for DIV/DIVU, result {remainder, quotient}
// Optional DIV_ZERO_FLAG_EN drives div_zero_o for zero-divisor requests.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH:0]     work;
  logic [WIDTH-1:0]     divisor;
  logic                 q_neg, r_neg;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  logic                 a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]     abs_a, abs_b, quot, rem;
  logic [WIDTH:0]       trial;

  always_comb begin
    a_neg    = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    b_neg    = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    abs_a    = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    abs_b    = b_neg ? -bus.opdata2_i : bus.opdata2_i;
    div_zero = (bus.opdata2_i == '0);
    // Partial remainder is WIDTH+1 bits so divisors above 2^(WIDTH-1) still resolve correctly.
    trial    = work[2*WIDTH:WIDTH] - {1'b0, divisor};
    quot     = q_neg ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem      = r_neg ? -work[2*WIDTH:WIDTH+1] : work[2*WIDTH:WIDTH+1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE:    if (bus.start_i && !bus.annul_i) state_nxt = div_zero ? BY_ZERO : ON;
      BY_ZERO: state_nxt = END;
      ON: begin
        if (bus.annul_i)              state_nxt = FREE;
        else if (cnt == CW'(WIDTH))   state_nxt = END;
      end
      END:     if (!bus.start_i) state_nxt = FREE;
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (bus.start_i && !bus.annul_i && !div_zero) begin
            cnt     <= '0;
            work    <= {{WIDTH{1'b0}}, abs_a, 1'b0};
            divisor <= abs_b;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
          end
        end
        BY_ZERO: begin
          result_q <= '0;
          ready_q  <= 1'b1;
        end
        ON: begin
          if (bus.annul_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
          end else if (cnt != CW'(WIDTH)) begin
            work <= trial[WIDTH] ? {work[2*WIDTH-1:0], 1'b0}
                                 : {trial[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
            cnt  <= cnt + 1'b1;
          end else begin
            result_q <= {rem, quot};
            ready_q  <= 1'b1;
          end
        end
        END: begin
          if (!bus.start_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic div_zero_q;

  always_ff @(posedge clk) begin
    if (rst)                                 div_zero_q <= 1'b0;
    else if (state == BY_ZERO)               div_zero_q <= 1'b1;
    else if (state == END && !bus.start_i)   div_zero_q <= 1'b0;
    else if (state == FREE)                  div_zero_q <= 1'b0;
  end

  assign bus.div_zero_o = div_zero_q;
`endif

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flag(input string tag, input logic exp);
`ifdef DIV_ZERO_FLAG_EN
    chk(tag, 64'(bus.div_zero_o), 64'(exp));
`endif
  endtask

  task automatic drive(input logic sd, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
  endtask

  // Request edge E0 is the next posedge after this call; result must appear after E33, not E32.
  task automatic run(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input bit glitch);
    drive(sd, a, b);
    bus.start_i = 1'b1;
    if (glitch) begin
      tick(5);
      bus.start_i = 1'b0;
      drive(~sd, 32'h1234_5678, 32'h0000_0003);
      tick(10);
      bus.start_i = 1'b1;
      tick(18);
    end else begin
      tick(33);
    end
    chk({tag, "_early"}, 64'(bus.ready_o), 64'd0);
    tick(1);
    chk({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    chk({tag, "_result"}, bus.result_o, exp);
    chk_flag({tag, "_dz"}, 1'b0);
  endtask

  task automatic release_req(input string tag);
    bus.start_i = 1'b0;
    tick(1);
    chk({tag, "_rel_ready"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_rel_result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    tick(2);
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    chk_flag("reset_dz", 1'b0);
    rst = 1'b0;
    tick(1);

    // Unsigned 100/7, then hold start for 5 cycles with operand and annul noise.
    run("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.annul_i = i[0];
      tick(1);
      chk("hold_ready", 64'(bus.ready_o), 64'd1);
      chk("hold_result", bus.result_o, {32'd2, 32'd14});
    end
    bus.annul_i = 1'b0;
    release_req("u100_7");

    run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    release_req("s_m7_2");

    run("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
    release_req("s_7_m2");

    run("s_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'h0000_0002}, 1'b0);
    release_req("s_m8_m3");

    run("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0);
    release_req("s_ovf");

    // Large unsigned divisor with start dropped and operands changed mid-run.
    run("u_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'h0000_0001, 32'h0000_0001}, 1'b1);
    release_req("u_big");

    // Zero divisor: BY_ZERO at E0, END after E1.
    drive(1'b0, 32'd5, 32'd0);
    bus.start_i = 1'b1;
    tick(1);
    chk("dz_e0_ready", 64'(bus.ready_o), 64'd0);
    tick(1);
    chk("dz_e1_ready", 64'(bus.ready_o), 64'd1);
    chk("dz_e1_result", bus.result_o, 64'd0);
    chk_flag("dz_e1_flag", 1'b1);
    tick(2);
    chk("dz_hold_ready", 64'(bus.ready_o), 64'd1);
    chk_flag("dz_hold_flag", 1'b1);
    release_req("dz");
    chk_flag("dz_rel_flag", 1'b0);

    // Annul sampled at E10, then an immediate new request.
    drive(1'b0, 32'd1000, 32'd3);
    bus.start_i = 1'b1;
    tick(10);
    bus.annul_i = 1'b1;
    tick(1);
    chk("annul_ready", 64'(bus.ready_o), 64'd0);
    chk("annul_result", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    run("after_annul", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0);
    release_req("after_annul");

    // Reset in the middle of ON.
    drive(1'b0, 32'd77, 32'd5);
    bus.start_i = 1'b1;
    tick(15);
    rst = 1'b1;
    tick(1);
    chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_on_result", bus.result_o, 64'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    tick(1);
    run("after_rst", 1'b0, 32'd77, 32'd5, {32'd2, 32'd15}, 1'b0);
    release_req("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit divider that acts as the responder to the EX stage for DIV/DIVU.
- EX issues an operand pair with a level-held start request. div_unit runs a one-bit-per-cycle restoring (trial-subtraction) division.
- The result is returned as {remainder, quotient}, which EX forwards on its HI/LO write path (HI = remainder, LO = quotient).
- While ready_o is low, EX stalls the pipeline.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- signed_div_i  input  1  1 = signed DIV, 0 = unsigned DIVU
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  request; held high by EX until it has consumed the result
- annul_i  input  1  cancel the in-flight division (branch-delay flush / exception)
- result_o  output  2*WIDTH  {remainder, quotient}
- ready_o  output  1  result valid

Behaviour:
- Reset: rst sampled high puts state = FREE, result_o = 0, ready_o = 0, cnt = 0. This applies mid-operation too; any in-flight division is discarded.
- States: FREE, BY_ZERO, ON, END.
- FREE, when start_i=1 and annul_i=0:
  - Divisor == 0 → BY_ZERO.
  - Otherwise → ON with cnt = 0. Operands are captured into internal registers at this edge; later input changes are ignored.
  - In signed mode, each negative operand is replaced by its two's complement (absolute value) at capture.
  - Working register = {WIDTH zeros, |dividend|, 1'b0}.
- FREE, otherwise: stay; ready_o = 0, result_o = 0.
- BY_ZERO: next edge → END with result_o = 0.
- ON, annul_i=1: → FREE at the next edge; ready_o = 0, result_o = 0.
- ON, cnt != WIDTH: one iteration per edge:
  - Compute the trial = upper partial remainder − |divisor|.
  - If the trial is negative, shift in 0. Otherwise load the trial and shift in 1.
  - cnt increments.
- ON, cnt == WIDTH: finalize on this edge and go → END.
  - Signed: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - result_o = {remainder, quotient}; ready_o = 1.
- Latency: the edge that samples start_i is E0. Iterations occur on E1..E32, finalize on E33, so ready_o is high after E33.
  - Divide-by-zero: ready_o is high after E1 (BY_ZERO→END at E1).
- END:
  - While start_i=1: hold ready_o = 1 and result_o stable.
  - When start_i=0: → FREE at the next edge; ready_o = 0, result_o = 0.
  - annul_i has no effect in END.
- Signed overflow (0x80000000 / 0xFFFFFFFF) returns quotient 0x80000000, remainder 0. No trap.
- start_i dropping while in ON is ignored; only annul_i aborts.
- Arithmetic: the trial subtraction is done in WIDTH+1 bits, and the sign bit of the trial selects the outcome.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined: adds output div_zero_o (1 bit).
  - Set in the END state reached via BY_ZERO; it is 1 exactly while ready_o = 1 for a zero-divisor request.
  - Reset value 0; it clears together with ready_o.
- Undefined: the port is absent. Divide-by-zero is distinguishable only by its latency, with result 0.

Test Plan:
- Unsigned 100/7: signed_div_i=0, opdata1_i=100, opdata2_i=7, start_i held → ready_o rises after E33; result_o = {32'd2, 32'd14}.
- Signed −7/2: opdata1_i=0xFFFFFFF9, opdata2_i=2 → result_o = {0xFFFFFFFF, 0xFFFFFFFD}, i.e. remainder −1, quotient −3.
- Signed overflow 0x80000000/0xFFFFFFFF → result_o = {0x00000000, 0x80000000}.
- Zero divisor 5/0 → ready_o high after E1; result_o = 0; div_zero_o = 1 if DIV_ZERO_FLAG_EN is defined.
- Annul at E10 → next cycle ready_o = 0, state FREE. A new request of 0xFFFFFFFF/1 (unsigned) then gives {0, 0xFFFFFFFF} after E33.
- Handshake hold: keep start_i high 5 cycles past ready_o → result_o stable and ready_o = 1 throughout. Drop start_i → ready_o = 0 and result_o = 0 one edge later. Assert rst mid-ON → ready_o = 0 and result_o = 0 after that edge.
